peripheral: RTL and testbench

- Memory-mapped peripheral bus slave for the single-cycle MIPS CPU, decoding 0x40000000–0x40000020.
- Contains a 32-bit reload timer, 8 LEDs, 8 switches, a 12-bit 7-segment digit register and an 8N1 UART.
- Exposes two interrupt lines to the CPU, masked while the CPU runs in kernel mode (PC31=1).

---
 rtl/peripheral_if.sv | 12 +
 rtl/peripheral.sv | 268 ++++++++++++++++++++++++++
 tb/tb_peripheral.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_if.sv
// CPU-side peripheral bus: read/write strobes, byte address, write data and
// combinational read data returned by the slave.
interface peripheral_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input  rdata);
    modport slave  (input  rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/peripheral.sv
// Memory-mapped peripheral slave at 0x40000000-0x40000020: reload timer,
// LEDs, switches, 7-segment digit register and an 8N1 UART with two
// interrupt lines that are masked while the CPU runs in kernel mode.
module peripheral #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    peripheral_if.slave bus,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic [1:0]  irqout,
    input  logic        UART_RX,
    output logic        UART_TX,
    input  logic        PC31
);

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
    localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI = 32'h4000_0014;
    localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON  = 32'h4000_0020;

    localparam int unsigned      CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;

    // Timer and GPIO registers
    logic [31:0] th_q, tl_q;
    logic [2:0]  tcon_q;
    logic [7:0]  led_q;
    logic [11:0] digi_q;

    // UART control/status
    logic [1:0]  con_en_q;
    logic        con_rx_done_q, con_tx_done_q;
    logic [4:0]  con_value;

    // Receiver
    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q, rxd_q;
    logic             rx_done_q;

    // Transmitter
    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_bit_q;
    logic [8:0]       tx_shift_q;
    logic [7:0]       txd_q;
    logic             tx_q, tx_busy_q, tx_done_q;

    // Address decode
    logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd, wr_con, rd_con;
    logic tl_wrap, tx_start;

    assign wr_th    = bus.wr && (bus.addr == ADDR_TH);
    assign wr_tl    = bus.wr && (bus.addr == ADDR_TL);
    assign wr_tcon  = bus.wr && (bus.addr == ADDR_TCON);
    assign wr_led   = bus.wr && (bus.addr == ADDR_LED);
    assign wr_digi  = bus.wr && (bus.addr == ADDR_DIGI);
    assign wr_txd   = bus.wr && (bus.addr == ADDR_TXD);
    assign wr_con   = bus.wr && (bus.addr == ADDR_CON);
    assign rd_con   = bus.rd && (bus.addr == ADDR_CON);
    assign tl_wrap  = (tl_q == 32'hFFFF_FFFF);
    assign tx_start = wr_txd && !tx_busy_q;

    assign con_value = {tx_busy_q, con_tx_done_q, con_rx_done_q, con_en_q};

    // Timer: count TL up, reload from TH on wrap; CPU writes take priority
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            if (wr_th) th_q <= bus.wdata;

            if (wr_tl)               tl_q <= bus.wdata;
            else if (tcon_q[0])      tl_q <= tl_wrap ? th_q : tl_q + 32'd1;

            if (wr_tcon)                              tcon_q    <= bus.wdata[2:0];
            else if (tcon_q[0] && tl_wrap && tcon_q[1]) tcon_q[2] <= 1'b1;
        end
    end

    // LED and 7-segment registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            if (wr_led)  led_q  <= bus.wdata[7:0];
            if (wr_digi) digi_q <= bus.wdata[11:0];
        end
    end

    // UART control: enables are writable, done flags set by the FSMs and
    // cleared by a read; a new event in the same cycle as the read wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            con_en_q      <= '0;
            con_rx_done_q <= 1'b0;
            con_tx_done_q <= 1'b0;
        end else begin
            if (wr_con) con_en_q <= bus.wdata[1:0];

            if (rx_done_q)   con_rx_done_q <= 1'b1;
            else if (rd_con) con_rx_done_q <= 1'b0;

            if (tx_done_q)   con_tx_done_q <= 1'b1;
            else if (rd_con) con_tx_done_q <= 1'b0;
        end
    end

    // Combinational read mux, zero for unmapped addresses or rd low
    // NOTE: the default assignment up front keeps this block from inferring a latch.
    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            case (bus.addr)
                ADDR_TH:   bus.rdata = th_q;
                ADDR_TL:   bus.rdata = tl_q;
                ADDR_TCON: bus.rdata = {29'd0, tcon_q};
                ADDR_LED:  bus.rdata = {24'd0, led_q};
                ADDR_SW:   bus.rdata = {24'd0, switch};
                ADDR_DIGI: bus.rdata = {20'd0, digi_q};
                ADDR_TXD:  bus.rdata = {24'd0, txd_q};
                ADDR_RXD:  bus.rdata = {24'd0, rxd_q};
                ADDR_CON:  bus.rdata = {27'd0, con_value};
                default:   bus.rdata = '0;
            endcase
        end
    end

    // Interrupts, masked in kernel mode
    assign irqout[0] = tcon_q[2] & ~PC31;
    assign irqout[1] = ((con_rx_done_q & con_en_q[1]) | (con_tx_done_q & con_en_q[0])) & ~PC31;

    assign led     = led_q;
    assign digi    = digi_q;
    assign UART_TX = tx_q;

    // Two-flop synchronizer for the asynchronous serial input (idles high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver: detect start edge, verify at mid-bit, then sample each bit
    // centre; only a valid stop bit commits the byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rxd_q      <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            rxd_q     <= rx_shift_q;
                            rx_done_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: start bit driven on the accepting edge, then data bits
    // and stop bit shifted out, each held BAUD_DIV cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            txd_q      <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        txd_q      <= bus.wdata[7:0];
                        tx_shift_q <= {1'b1, bus.wdata[7:0]};
                        tx_q       <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_q <= TX_IDLE;
                            tx_busy_q  <= 1'b0;
                            tx_done_q  <= 1'b1;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral.sv
// Self-checking bench for the peripheral: GPIO, timer reload/IRQ, UART TX
// framing, UART RX with glitch and framing-error rejection, and reset.
module tb_peripheral;

    localparam int          BD        = 32;
    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_SW      = 32'h4000_0010;
    localparam logic [31:0] A_DIGI    = 32'h4000_0014;
    localparam logic [31:0] A_TXD     = 32'h4000_0018;
    localparam logic [31:0] A_RXD     = 32'h4000_001C;
    localparam logic [31:0] A_CON     = 32'h4000_0020;
    localparam logic [31:0] A_UNMAP   = 32'h4000_0024;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led, sw;
    logic [11:0] digi;
    logic [1:0]  irqout;
    logic        uart_rx, uart_tx, pc31;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    peripheral_if bus();

    peripheral #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .led     (led),
        .switch  (sw),
        .digi    (digi),
        .irqout  (irqout),
        .UART_RX (uart_rx),
        .UART_TX (uart_tx),
        .PC31    (pc31)
    );

    // One-cycle bus write; entered and left just after a rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.wr = 1'b0;
    endtask

    // One-cycle bus read sampled on the falling edge
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.rd = 1'b1; bus.addr = a;
        @(negedge clk);
        d = bus.rdata;
        @(posedge clk); #1;
        bus.rd = 1'b0;
    endtask

    // Drive one serial byte (start, 8 data LSB first, given stop level)
    task automatic send_rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (BD) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = A_RXD; bus.wdata = '0;
        uart_rx = 1'b1; pc31 = 1'b0; sw = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        n_vec++; if (uart_tx !== 1'b1)    begin n_err++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        n_vec++; if (led !== 8'h00)       begin n_err++; $display("FAIL reset_led: got %h want 00", led); end
        n_vec++; if (digi !== 12'h000)    begin n_err++; $display("FAIL reset_digi: got %h want 000", digi); end
        n_vec++; if (irqout !== 2'b00)    begin n_err++; $display("FAIL reset_irq: got %b want 00", irqout); end
        @(posedge clk); #1;
        reset = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic test_gpio();
        logic [31:0] rd_addr [5];
        logic [31:0] d, e;
        sw = 8'h3C;
        bus_write(A_LED, 32'h0000_00A5);
        bus_write(A_DIGI, 32'h0000_0ABC);
        bus_write(A_SW, 32'hFFFF_FFFF);      // read-only, must be ignored
        bus_write(A_UNMAP, 32'h1234_5678);   // unmapped, must be ignored
        n_vec++; if (led !== 8'hA5)   begin n_err++; $display("FAIL gpio_led_port: got %h want a5", led); end
        n_vec++; if (digi !== 12'hABC) begin n_err++; $display("FAIL gpio_digi_port: got %h want abc", digi); end
        rd_addr = '{A_SW, A_LED, A_DIGI, A_UNMAP, A_TH};
        exp_q.push_back(32'h3C); exp_q.push_back(32'hA5); exp_q.push_back(32'hABC);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h0);
        foreach (rd_addr[i]) begin
            bus_read(rd_addr[i], d);
            e = exp_q.pop_front();
            n_vec++; if (d !== e) begin n_err++; $display("FAIL gpio_read @%h: got %h want %h", rd_addr[i], d, e); end
        end
        bus.addr = A_LED; bus.rd = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL gpio_rd_low: got %h want 0", bus.rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_timer();
        logic [31:0] m_th, m_tl, d, e;
        logic        m_st;
        m_th = 32'hFFFF_FFFE; m_tl = 32'hFFFF_FFFD; m_st = 1'b0;
        bus_write(A_TH, m_th);
        bus_write(A_TL, m_tl);
        bus_write(A_TCON, 32'd3);
        bus.rd = 1'b1; bus.addr = A_TL;
        for (int c = 0; c < 6; c++) begin
            exp_q.push_back(m_tl);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++; if (bus.rdata !== e) begin n_err++; $display("FAIL timer_tl c=%0d: got %h want %h", c, bus.rdata, e); end
            n_vec++; if (irqout[0] !== m_st) begin n_err++; $display("FAIL timer_irq c=%0d: got %b want %b", c, irqout[0], m_st); end
            @(posedge clk); #1;
            if (m_tl == 32'hFFFF_FFFF) begin m_tl = m_th; m_st = 1'b1; end
            else m_tl = m_tl + 32'd1;
        end
        bus.rd = 1'b0;
        bus_read(A_TCON, d);
        n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL timer_tcon: got %h want 7", d); end
        n_vec++; if (irqout[0] !== 1'b1) begin n_err++; $display("FAIL timer_irq_set: got %b want 1", irqout[0]); end
        pc31 = 1'b1; #1;
        n_vec++; if (irqout[0] !== 1'b0) begin n_err++; $display("FAIL timer_irq_kernel: got %b want 0", irqout[0]); end
        pc31 = 1'b0;
        bus_write(A_TCON, 32'd3);
        n_vec++; if (irqout[0] !== 1'b0) begin n_err++; $display("FAIL timer_irq_clear: got %b want 0", irqout[0]); end
        bus_write(A_TCON, 32'd0);
        repeat (4) @(posedge clk); #1;
        n_vec++; if (irqout[0] !== 1'b0) begin n_err++; $display("FAIL timer_stopped_irq: got %b want 0", irqout[0]); end
    endtask

    task automatic test_tx();
        logic [9:0]  frame;
        logic [31:0] d;
        logic        cur, saw_low;
        frame = {1'b1, 8'h55, 1'b0};
        cur   = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({31'd0, frame[i]});
        bus_write(A_TXD, 32'h0000_0055);
        for (int c = 0; c < 10 * BD + 4; c++) begin
            if (c % BD == 0 && c < 10 * BD) cur = exp_q.pop_front() != 0;
            else if (c == 10 * BD) cur = 1'b1;
            if (c == 5)  begin bus.wr = 1'b1; bus.addr = A_TXD; bus.wdata = 32'hAA; end
            if (c == 40) begin bus.rd = 1'b1; bus.addr = A_CON; end
            @(negedge clk);
            n_vec++; if (uart_tx !== cur) begin n_err++; $display("FAIL tx_bit c=%0d: got %b want %b", c, uart_tx, cur); end
            if (c == 40) begin
                n_vec++; if (bus.rdata !== 32'h10) begin n_err++; $display("FAIL tx_con_busy: got %h want 10", bus.rdata); end
            end
            @(posedge clk); #1;
            bus.wr = 1'b0; bus.rd = 1'b0;
        end
        bus_read(A_CON, d);
        n_vec++; if (d !== 32'h08) begin n_err++; $display("FAIL tx_con_done: got %h want 08", d); end
        bus_read(A_TXD, d);
        n_vec++; if (d !== 32'h55) begin n_err++; $display("FAIL tx_txd: got %h want 55", d); end
        saw_low = 1'b0;
        for (int c = 0; c < 3 * BD; c++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        @(posedge clk); #1;
        n_vec++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL tx_extra_frame: got low=%b want 0", saw_low); end
    endtask

    task automatic test_rx();
        logic [39:0] pat;
        logic [31:0] d, e;
        int          used;
        pat = 40'hFFFF_A7FF_96;
        bus_write(A_CON, 32'h2);
        exp_q.push_back(32'hCB); exp_q.push_back(32'hFA);
        exp_q.push_back(32'hCB); exp_q.push_back(32'hFA);
        for (int idx = 0; idx < 80; idx++) begin
            uart_rx = pat[idx % 40];
            used = 0;
            if (idx % 40 == 12 || idx % 40 == 31) begin
                e = exp_q.pop_front();
                n_vec++; if (irqout[1] !== 1'b1) begin n_err++; $display("FAIL rx_irq idx=%0d: got %b want 1", idx, irqout[1]); end
                pc31 = 1'b1; #1;
                n_vec++; if (irqout[1] !== 1'b0) begin n_err++; $display("FAIL rx_irq_kernel idx=%0d: got %b want 0", idx, irqout[1]); end
                pc31 = 1'b0;
                bus_read(A_RXD, d); used++;
                n_vec++; if (d !== e) begin n_err++; $display("FAIL rx_byte idx=%0d: got %h want %h", idx, d, e); end
                bus_read(A_CON, d); used++;
                n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL rx_con idx=%0d: got %h want 6", idx, d); end
                n_vec++; if (irqout[1] !== 1'b0) begin n_err++; $display("FAIL rx_irq_cleared idx=%0d: got %b want 0", idx, irqout[1]); end
            end
            repeat (BD - used) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_rx_errors();
        logic [31:0] d, e;
        // 10-cycle glitch must not start a reception
        uart_rx = 1'b0;
        repeat (10) @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (3 * BD) @(posedge clk); #1;
        exp_q.push_back(32'hFA);
        bus_read(A_RXD, d); e = exp_q.pop_front();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL glitch_rxd: got %h want %h", d, e); end
        bus_read(A_CON, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL glitch_con: got %h want 2", d); end
        // stop bit low: byte discarded, flags unchanged
        send_rx_frame(8'h33, 1'b0);
        repeat (3 * BD) @(posedge clk); #1;
        exp_q.push_back(32'hFA);
        bus_read(A_RXD, d); e = exp_q.pop_front();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL framing_rxd: got %h want %h", d, e); end
        bus_read(A_CON, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL framing_con: got %h want 2", d); end
        // receiver recovers and takes the next good byte
        send_rx_frame(8'h3C, 1'b1);
        repeat (BD) @(posedge clk); #1;
        exp_q.push_back(32'h3C);
        bus_read(A_RXD, d); e = exp_q.pop_front();
        n_vec++; if (d !== e) begin n_err++; $display("FAIL recover_rxd: got %h want %h", d, e); end
        bus_read(A_CON, d);
        n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL recover_con: got %h want 6", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic        saw_low;
        bus_write(A_TXD, 32'h0000_000F);
        repeat (BD / 2) @(posedge clk); #2;
        n_vec++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL midframe_start: got %b want 0", uart_tx); end
        reset = 1'b1; #1;
        n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL midframe_tx: got %b want 1", uart_tx); end
        n_vec++; if (led !== 8'h00)    begin n_err++; $display("FAIL midframe_led: got %h want 00", led); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(A_CON, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midframe_con: got %h want 0", d); end
        bus_read(A_TXD, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midframe_txd: got %h want 0", d); end
        saw_low = 1'b0;
        for (int c = 0; c < 2 * BD; c++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        @(posedge clk); #1;
        n_vec++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL midframe_idle: got low=%b want 0", saw_low); end
    endtask

    initial begin
        test_reset();
        test_gpio();
        test_timer();
        test_tx();
        test_rx();
        test_rx_errors();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
